// File: rtl/fde_pkg.sv
// rtl/fde_pkg.sv - opcode constants, sequencer state encoding and the writes() decode.
package fde_pkg;

  localparam logic [15:0] OP_ADD = 16'h1;
  localparam logic [15:0] OP_SUB = 16'h2;
  localparam logic [15:0] OP_LDI = 16'h3;
  localparam logic [15:0] OP_SHL = 16'h4;
  localparam logic [15:0] OP_SHR = 16'h5;
  localparam logic [15:0] OP_AND = 16'h6;
  localparam logic [15:0] OP_OR  = 16'h7;
  localparam logic [15:0] OP_XOR = 16'h8;
  localparam logic [15:0] OP_BR  = 16'h9;
  localparam logic [15:0] OP_BNE = 16'hA;
  localparam logic [15:0] OP_MOV = 16'hB;
  localparam logic [15:0] OP_ADI = 16'hC;
  localparam logic [15:0] OP_MUL = 16'hD;
  localparam logic [15:0] OP_HLT = 16'hE;
  localparam logic [15:0] OP_NOP = 16'hF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  // True when the opcode produces a register result.
  function automatic logic writes(input logic [15:0] op);
    return op inside {[OP_ADD:OP_XOR], OP_MOV, OP_ADI, OP_MUL};
  endfunction

endpackage

// File: rtl/pipe_sequencer_if.sv
// rtl/pipe_sequencer_if.sv - decode/execute status in, stage-register controls out.
interface pipe_sequencer_if #(
  parameter int OPW = 16,
  parameter int RW  = 5
);
  logic           start;
  logic           id_valid;
  logic [OPW-1:0] id_opcode;
  logic [RW-1:0]  id_src_a;
  logic [RW-1:0]  id_src_b;
  logic [OPW-1:0] ex_opcode;
  logic [RW-1:0]  ex_dst;
  logic           branch_taken;
  logic           pc_en;
  logic           if_id_en;
  logic           if_id_flush;
  logic           id_ex_en;
  logic           id_ex_bubble;
  logic           ex_wb_en;
  logic           halted;
  logic           busy;

  modport master (
    input  start, id_valid, id_opcode, id_src_a, id_src_b, ex_opcode, ex_dst, branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_wb_en, halted, busy
  );

  modport slave (
    output start, id_valid, id_opcode, id_src_a, id_src_b, ex_opcode, ex_dst, branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_wb_en, halted, busy
  );
endinterface

// File: rtl/pipe_sequencer_hazard_detect.sv
// rtl/pipe_sequencer_hazard_detect.sv - combinational RAW compare between decode sources and execute destination.
module hazard_detect
  import fde_pkg::*;
#(
  parameter int OPW = 16,
  parameter int RW  = 5
) (
  input  logic           id_valid,
  input  logic           ex_valid,
  input  logic [OPW-1:0] ex_opcode,
  input  logic [RW-1:0]  ex_dst,
  input  logic [RW-1:0]  id_src_a,
  input  logic [RW-1:0]  id_src_b,
  output logic           hazard
);
  // r0 is hardwired zero, so a write to it never creates a dependency.
  always_comb begin
    hazard = id_valid && ex_valid && writes(16'(ex_opcode)) && (ex_dst != '0) &&
             ((id_src_a == ex_dst) || (id_src_b == ex_dst));
  end
endmodule

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - pipeline sequencer: stage enables, RAW stall, MUL wait, branch flush, halt.
// Optional PIPE_SEQUENCER_PERF_EN adds saturating stall/flush/mul-wait counters.
module pipe_sequencer
  import fde_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int OPW        = 16,
  parameter int RW         = 5
) (
  input  logic clock,
  input  logic reset,
  pipe_sequencer_if.master bus
`ifdef PIPE_SEQUENCER_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] mul_wait_cnt
`endif
);
  localparam int            CW       = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           ex_valid_q, ex_valid_n;
  logic           pc_en_q, if_id_en_q, if_id_flush_q, id_ex_en_q, id_ex_bubble_q;
  logic           ex_wb_en_q, halted_q, busy_q;
  logic           pc_en_n, if_id_en_n, if_id_flush_n, id_ex_en_n, id_ex_bubble_n;
  logic           ex_wb_en_n, halted_n, busy_n;
  logic           hazard, halt_hit, ex_wr;
  logic [OPW-1:0] ex_op, id_op;

  assign ex_op = bus.ex_opcode;
  assign id_op = bus.id_opcode;

  hazard_detect #(.OPW(OPW), .RW(RW)) u_hazard (
    .id_valid  (bus.id_valid),
    .ex_valid  (ex_valid_q),
    .ex_opcode (ex_op),
    .ex_dst    (bus.ex_dst),
    .id_src_a  (bus.id_src_a),
    .id_src_b  (bus.id_src_b),
    .hazard    (hazard)
  );

  assign halt_hit = ex_valid_q && (16'(ex_op) == OP_HLT);
  assign ex_wr    = ex_valid_q && writes(16'(ex_op));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      ex_valid_q     <= 1'b0;
      pc_en_q        <= 1'b0;
      if_id_en_q     <= 1'b0;
      if_id_flush_q  <= 1'b0;
      id_ex_en_q     <= 1'b0;
      id_ex_bubble_q <= 1'b1;
      ex_wb_en_q     <= 1'b0;
      halted_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      ex_valid_q     <= ex_valid_n;
      pc_en_q        <= pc_en_n;
      if_id_en_q     <= if_id_en_n;
      if_id_flush_q  <= if_id_flush_n;
      id_ex_en_q     <= id_ex_en_n;
      id_ex_bubble_q <= id_ex_bubble_n;
      ex_wb_en_q     <= ex_wb_en_n;
      halted_q       <= halted_n;
      busy_q         <= busy_n;
    end
  end

  // The EX slot is marked dead whenever what it holds must not be written back
  // again or at all: behind HLT, behind a taken branch, or a MUL already retired.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    ex_valid_n     = id_ex_en_q ? (bus.id_valid && !id_ex_bubble_q) : ex_valid_q;
    pc_en_n        = 1'b0;
    if_id_en_n     = 1'b0;
    if_id_flush_n  = 1'b0;
    id_ex_en_n     = 1'b0;
    id_ex_bubble_n = 1'b1;
    ex_wb_en_n     = 1'b0;
    halted_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (halt_hit) begin
          state_n    = ST_HALT;
          halted_n   = 1'b1;
          ex_valid_n = 1'b0;
        end else begin
          ex_wb_en_n = ex_wr;
          if (bus.branch_taken) begin
            state_n       = ST_FLUSH;
            pc_en_n       = 1'b1;
            if_id_flush_n = 1'b1;
            id_ex_en_n    = 1'b1;
            ex_valid_n    = 1'b0;
          end else if (hazard) begin
            id_ex_en_n = 1'b1;
          end else begin
            pc_en_n        = 1'b1;
            if_id_en_n     = 1'b1;
            id_ex_en_n     = 1'b1;
            id_ex_bubble_n = !bus.id_valid;
            if ((MUL_CYCLES > 1) && bus.id_valid && (16'(id_op) == OP_MUL)) begin
              state_n = ST_MUL_WAIT;
              cnt_n   = CNT_LOAD;
            end
          end
        end
      end
      ST_MUL_WAIT: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n    = ST_RUN;
          ex_wb_en_n = ex_wr;
          ex_valid_n = 1'b0;
        end
      end
      ST_FLUSH: begin
        state_n    = ST_RUN;
        pc_en_n    = 1'b1;
        if_id_en_n = 1'b1;
        id_ex_en_n = 1'b1;
        ex_wb_en_n = ex_wr;
      end
      ST_HALT: begin
        halted_n = 1'b1;
        if (bus.start) begin
          state_n  = ST_RUN;
          halted_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE) && (state_n != ST_HALT);
  end

  assign bus.pc_en        = pc_en_q;
  assign bus.if_id_en     = if_id_en_q;
  assign bus.if_id_flush  = if_id_flush_q;
  assign bus.id_ex_en     = id_ex_en_q;
  assign bus.id_ex_bubble = id_ex_bubble_q;
  assign bus.ex_wb_en     = ex_wb_en_q;
  assign bus.halted       = halted_q;
  assign bus.busy         = busy_q;

`ifdef PIPE_SEQUENCER_PERF_EN
  logic run_live;
  assign run_live = (state == ST_RUN) && !halt_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      mul_wait_cnt <= '0;
    end else begin
      if (run_live && !bus.branch_taken && hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (run_live && bus.branch_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
      if ((state == ST_MUL_WAIT) && (mul_wait_cnt != '1))
        mul_wait_cnt <= mul_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Central controller for the fetch/decode/execute/writeback pipeline; drives the stage-register enables around the execute stage (ID_EX, EX_WB).
- Detects RAW hazards between decode and execute (no forwarding), holds the pipe while a multi-cycle MUL (16'hD) runs, flushes after a taken branch (BR 16'h9, BNE 16'hA), and stops on HLT (16'hE).
- Single instance beside the execute stage.

Parameters:
- MUL_CYCLES, 3: execute-stage cycles for MUL (>=1); 1 means no wait state.
- OPW, 16: opcode field width (ID_EX[175:160]).
- RW, 5: register address width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin or resume execution (pulse).
- id_valid  in  1  decode holds a real instruction.
- id_opcode  in  OPW  opcode in decode.
- id_src_a  in  RW  decode source register A.
- id_src_b  in  RW  decode source register B.
- ex_opcode  in  OPW  opcode in execute (ID_EX[175:160]).
- ex_dst  in  RW  execute destination (EX_WB[4:0]).
- branch_taken  in  1  execute resolved a taken BR/BNE this cycle.
- pc_en  out  1  PC advance/load enable.
- if_id_en  out  1  IF/ID register load.
- if_id_flush  out  1  clear IF/ID to NOP (16'hF).
- id_ex_en  out  1  ID/EX register load.
- id_ex_bubble  out  1  load NOP into ID/EX instead of decode output.
- ex_wb_en  out  1  EX/WB result valid; writeback permitted.
- halted  out  1  HLT retired.
- busy  out  1  state is not IDLE or HALT.

Behaviour:
- Reset (reset=0, async): state IDLE, ex_valid_q=0, mul counter=0; outputs pc_en=0, if_id_en=0, if_id_flush=0, id_ex_en=0, id_ex_bubble=1, ex_wb_en=0, halted=0, busy=0.
- All outputs are registered. A decision made at edge N is visible after edge N.
- States: IDLE, RUN, MUL_WAIT, FLUSH, HALT.
- IDLE:
  - All enables 0.
  - start=1 -> RUN.
- RUN, priority high to low:
  1. ex_valid_q && ex_opcode==E -> HALT. All enables 0; instruction behind HLT is not issued.
  2. branch_taken -> FLUSH. This cycle: pc_en=1 (target load), if_id_flush=1, id_ex_en=1, id_ex_bubble=1.
  3. Hazard -> stay RUN. pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1. Hazard = id_valid && ex_valid_q && writes(ex_opcode) && ex_dst!=0 && (id_src_a==ex_dst || id_src_b==ex_dst).
  4. Issue of MUL (id_valid, id_opcode==D, no hazard) with MUL_CYCLES>1 -> MUL_WAIT, counter=MUL_CYCLES-1.
  5. Otherwise: pc_en=if_id_en=id_ex_en=1, id_ex_bubble=!id_valid.
- writes(op): true for opcodes 1-8, B, C, D; false for 9, A, E, F and undefined codes.
- ex_valid_q <= id_ex_en ? (id_valid && !id_ex_bubble) : ex_valid_q.
- ex_wb_en = ex_valid_q && writes(ex_opcode), except during MUL_WAIT.
- MUL_WAIT:
  - All enables 0, ex_wb_en=0; counter decrements each cycle.
  - At counter==1 -> RUN, with ex_wb_en=1 for the MUL result on the following cycle.
  - branch_taken is ignored here; MUL never branches.
- FLUSH: exactly one cycle.
  - if_id_en=1, pc_en=1, id_ex_en=1, id_ex_bubble=1. The wrong-path fetch is discarded.
  - Then -> RUN.
- HALT:
  - halted=1, all enables 0.
  - start=1 -> RUN and halted cleared. Other inputs are ignored.
- start in RUN, MUL_WAIT or FLUSH is ignored.
- Reset asserted mid-MUL or mid-flush aborts immediately to the reset values; no writeback occurs.

Optional Feature:
- Macro PIPE_SEQUENCER_PERF_EN.
- When defined, adds three 32-bit outputs: stall_cnt (hazard cycles), flush_cnt (FLUSH entries) and mul_wait_cnt (MUL_WAIT cycles).
  - Counters saturate at 32'hFFFF_FFFF, clear on reset, and hold in IDLE/HALT.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package fde_pkg holds:
  - opcode localparams: OP_ADD=1, OP_SUB=2, OP_LDI=3, OP_SHL=4, OP_SHR=5, OP_AND=6, OP_OR=7, OP_XOR=8, OP_BR=9, OP_BNE=A, OP_MOV=B, OP_ADI=C, OP_MUL=D, OP_HLT=E, OP_NOP=F;
  - the state encoding;
  - the writes() function.
- Sub-module hazard_detect: combinational RAW compare, shared with a future forwarding unit.

Test Plan:
- Reset, start, then ADD r3 followed by AND reading r7 -> no stall; pc_en=1 every cycle; ex_wb_en=1 two cycles after each issue.
- ADD r5 then SUB reading r5 -> exactly one cycle with pc_en=0, id_ex_bubble=1; SUB issues on the next cycle. Same sequence with r0 -> no stall.
- MUL with MUL_CYCLES=3 -> pipe frozen for 2 cycles; ex_wb_en pulses once after return to RUN; the next instruction issues right after.
- BNE taken (branch_taken=1) -> if_id_flush=1 for one cycle; two bubbles reach EX; the wrong-path opcode never raises ex_wb_en.
- HLT reaches EX -> halted=1 and all enables 0 for 20 cycles; start=1 -> RUN resumes, halted=0.
- reset=0 mid-MUL_WAIT (counter=1) -> all outputs return to reset values asynchronously; ex_wb_en stays 0.
